// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two read ports, two write ports and the reservation request.
// The master side (decode/writeback) drives addresses and writes; the register file answers on the slave side.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [DATA_W-1:0] rs_out;
   logic [DATA_W-1:0] rt_out;
   logic              we0;
   logic [ADDR_W-1:0] wa0;
   logic [DATA_W-1:0] wd0;
   logic              we1;
   logic [ADDR_W-1:0] wa1;
   logic [DATA_W-1:0] wd1;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rs_busy;
   logic              rt_busy;

   modport master (
      output rs, rt, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
      input  rs_out, rt_out, rs_busy, rt_busy
   );

   modport slave (
      input  rs, rt, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
      output rs_out, rt_out, rs_busy, rt_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Port 1 wins write collisions; reservations win over same-cycle writes.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_mp_if.slave    bus
);
   localparam int DEPTH     = 2 ** ADDR_W;
   localparam bit HAS_ZERO  = (ZERO_REG != 0);
   localparam bit BYPASS_EN = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   logic              wr0_ok;
   logic              wr1_ok;
   logic              rsv_ok;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   assign wr0_ok = bus.we0    && !(HAS_ZERO && (bus.wa0 == '0));
   assign wr1_ok = bus.we1    && !(HAS_ZERO && (bus.wa1 == '0));
   assign rsv_ok = bus.rsv_en && !(HAS_ZERO && (bus.rsv_addr == '0));

   // Ordering encodes priority: port 1 overrides port 0, reservation overrides both clears.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr0_ok) begin
         regs_d[bus.wa0] = bus.wd0;
         busy_d[bus.wa0] = 1'b0;
      end
      if (wr1_ok) begin
         regs_d[bus.wa1] = bus.wd1;
         busy_d[bus.wa1] = 1'b0;
      end
      if (rsv_ok) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign rd_addr[0] = bus.rs;
   assign rd_addr[1] = bus.rt;

   // A bypassed write means the consumer already has valid data, so busy is masked too.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if (BYPASS_EN) begin
            if (bus.we1 && (bus.wa1 == rd_addr[p])) begin
               rd_data[p] = bus.wd1;
               rd_busy[p] = 1'b0;
            end else if (bus.we0 && (bus.wa0 == rd_addr[p])) begin
               rd_data[p] = bus.wd0;
               rd_busy[p] = 1'b0;
            end
         end
         if (HAS_ZERO && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign bus.rs_out  = rd_data[0];
   assign bus.rt_out  = rd_data[1];
   assign bus.rs_busy = rd_busy[0];
   assign bus.rt_busy = rd_busy[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing instance
// driven with identical inputs.
module tb_regfile_mp;
   logic clk;
   logic rst;
   int   vecs;
   int   errs;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) nbus ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk (clk),
      .rst (rst),
      .bus (nbus.slave)
   );

   assign nbus.rs       = bus.rs;
   assign nbus.rt       = bus.rt;
   assign nbus.we0      = bus.we0;
   assign nbus.wa0      = bus.wa0;
   assign nbus.wd0      = bus.wd0;
   assign nbus.we1      = bus.we1;
   assign nbus.wa1      = bus.wa1;
   assign nbus.wd1      = bus.wd1;
   assign nbus.rsv_en   = bus.rsv_en;
   assign nbus.rsv_addr = bus.rsv_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
      bus.rsv_en = 1'b0; bus.rsv_addr = '0;
   endtask

   task automatic test_reset();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
      tick();
      idle();
      bus.rs = 5'd5;
      #2;
      vecs++;
      if (bus.rs_out !== 32'hDEADBEEF) begin errs++; $display("FAIL reset_preload_data: got %h want %h", bus.rs_out, 32'hDEADBEEF); end
      vecs++;
      if (bus.rs_busy !== 1'b1) begin errs++; $display("FAIL reset_preload_busy: got %b want 1", bus.rs_busy); end
      rst = 1'b0;
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h1;
      tick();
      rst = 1'b1;
      idle();
      bus.rs = 5'd5; bus.rt = 5'd5;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h0) begin errs++; $display("FAIL reset_data: got %h want %h", bus.rs_out, 32'h0); end
      vecs++;
      if (bus.rs_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.rs_busy); end
      vecs++;
      if (nbus.rt_out !== 32'h0) begin errs++; $display("FAIL reset_data_nb: got %h want %h", nbus.rt_out, 32'h0); end
   endtask

   task automatic test_dual_write();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h11111111;
      bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h22222222;
      tick();
      idle();
      bus.rs = 5'd3; bus.rt = 5'd4;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h11111111) begin errs++; $display("FAIL dual_rs: got %h want %h", bus.rs_out, 32'h11111111); end
      vecs++;
      if (bus.rt_out !== 32'h22222222) begin errs++; $display("FAIL dual_rt: got %h want %h", bus.rt_out, 32'h22222222); end
      vecs++;
      if (nbus.rt_out !== 32'h22222222) begin errs++; $display("FAIL dual_rt_nb: got %h want %h", nbus.rt_out, 32'h22222222); end
   endtask

   task automatic test_collision();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'hAAAA0000;
      bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h5555FFFF;
      bus.rs = 5'd7;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h5555FFFF) begin errs++; $display("FAIL coll_bypass: got %h want %h", bus.rs_out, 32'h5555FFFF); end
      vecs++;
      if (nbus.rs_out !== 32'h0) begin errs++; $display("FAIL coll_nobypass: got %h want %h", nbus.rs_out, 32'h0); end
      tick();
      idle();
      bus.rs = 5'd7;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h5555FFFF) begin errs++; $display("FAIL coll_stored: got %h want %h", bus.rs_out, 32'h5555FFFF); end
      vecs++;
      if (nbus.rs_out !== 32'h5555FFFF) begin errs++; $display("FAIL coll_stored_nb: got %h want %h", nbus.rs_out, 32'h5555FFFF); end
   endtask

   task automatic test_bypass();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h10;
      tick();
      idle();
      bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h20;
      bus.rs = 5'd9; bus.rt = 5'd3;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h20) begin errs++; $display("FAIL byp_same: got %h want %h", bus.rs_out, 32'h20); end
      vecs++;
      if (nbus.rs_out !== 32'h10) begin errs++; $display("FAIL byp_same_nb: got %h want %h", nbus.rs_out, 32'h10); end
      vecs++;
      if (bus.rt_out !== 32'h11111111) begin errs++; $display("FAIL byp_other_port: got %h want %h", bus.rt_out, 32'h11111111); end
      tick();
      idle();
      bus.rs = 5'd9;
      #2;
      vecs++;
      if (nbus.rs_out !== 32'h20) begin errs++; $display("FAIL byp_next_nb: got %h want %h", nbus.rs_out, 32'h20); end
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      tick();
      idle();
      bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h30;
      bus.rs = 5'd9;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h30) begin errs++; $display("FAIL byp_port1: got %h want %h", bus.rs_out, 32'h30); end
      vecs++;
      if (bus.rs_busy !== 1'b0) begin errs++; $display("FAIL byp_busy_masked: got %b want 0", bus.rs_busy); end
      vecs++;
      if (nbus.rs_busy !== 1'b1) begin errs++; $display("FAIL byp_busy_nb: got %b want 1", nbus.rs_busy); end
      tick();
      idle();
      bus.rs = 5'd9;
      #2;
      vecs++;
      if (nbus.rs_busy !== 1'b0) begin errs++; $display("FAIL byp_busy_cleared: got %b want 0", nbus.rs_busy); end
   endtask

   task automatic test_zero();
      idle();
      bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFFFFFF;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      bus.rs = 5'd0;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h0) begin errs++; $display("FAIL zero_same_data: got %h want %h", bus.rs_out, 32'h0); end
      vecs++;
      if (bus.rs_busy !== 1'b0) begin errs++; $display("FAIL zero_same_busy: got %b want 0", bus.rs_busy); end
      tick();
      idle();
      bus.rs = 5'd0;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h0) begin errs++; $display("FAIL zero_next_data: got %h want %h", bus.rs_out, 32'h0); end
      vecs++;
      if (nbus.rs_busy !== 1'b0) begin errs++; $display("FAIL zero_next_busy: got %b want 0", nbus.rs_busy); end
   endtask

   task automatic test_scoreboard();
      idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12;
      tick();
      idle();
      bus.rt = 5'd12;
      #2;
      vecs++;
      if (bus.rt_busy !== 1'b1) begin errs++; $display("FAIL sb_reserved: got %b want 1", bus.rt_busy); end
      bus.we0 = 1'b1; bus.wa0 = 5'd12; bus.wd0 = 32'h12;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12;
      #2;
      vecs++;
      if (bus.rt_busy !== 1'b0) begin errs++; $display("FAIL sb_bypass_busy: got %b want 0", bus.rt_busy); end
      vecs++;
      if (nbus.rt_busy !== 1'b1) begin errs++; $display("FAIL sb_bypass_busy_nb: got %b want 1", nbus.rt_busy); end
      tick();
      idle();
      bus.rt = 5'd12;
      #2;
      vecs++;
      if (bus.rt_busy !== 1'b1) begin errs++; $display("FAIL sb_rsv_wins: got %b want 1", bus.rt_busy); end
      vecs++;
      if (bus.rt_out !== 32'h12) begin errs++; $display("FAIL sb_rsv_data: got %h want %h", bus.rt_out, 32'h12); end
      bus.we0 = 1'b1; bus.wa0 = 5'd12; bus.wd0 = 32'h34;
      tick();
      idle();
      bus.rt = 5'd12;
      #2;
      vecs++;
      if (bus.rt_busy !== 1'b0) begin errs++; $display("FAIL sb_released: got %b want 0", bus.rt_busy); end
      vecs++;
      if (nbus.rt_out !== 32'h34) begin errs++; $display("FAIL sb_final_data: got %h want %h", nbus.rt_out, 32'h34); end
   endtask

   task automatic test_mid_reset();
      idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd20;
      bus.we1 = 1'b1; bus.wa1 = 5'd21; bus.wd1 = 32'hCAFEF00D;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      idle();
      bus.rs = 5'd20; bus.rt = 5'd21;
      #2;
      vecs++;
      if (bus.rs_busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", bus.rs_busy); end
      vecs++;
      if (bus.rt_out !== 32'h0) begin errs++; $display("FAIL midrst_data: got %h want %h", bus.rt_out, 32'h0); end
      bus.rs = 5'd7; bus.rt = 5'd12;
      #2;
      vecs++;
      if (bus.rs_out !== 32'h0) begin errs++; $display("FAIL midrst_old_reg: got %h want %h", bus.rs_out, 32'h0); end
      vecs++;
      if (nbus.rt_out !== 32'h0) begin errs++; $display("FAIL midrst_old_reg_nb: got %h want %h", nbus.rt_out, 32'h0); end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rst = 1'b0;
      bus.rs = '0;
      bus.rt = '0;
      idle();
      repeat (2) tick();
      rst = 1'b1;
      tick();
      test_reset();
      test_dual_write();
      test_collision();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
